router_port_receiver: RTL and testbench

//  Receive side of one router output port. Samples the serial stream (dout/valido_n/frameo_n).

---
 rtl/router_port_receiver.sv | 184 ++++++++++++++++++
 tb/tb_router_port_receiver.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_port_receiver.sv
// router_port_receiver
//    Receive side of one router output port. Samples the serial stream
//    (dout / valido_n / frameo_n) and rebuilds LSB-first bytes. Each byte is
//    tagged with packet-end and malformed-packet flags. Tagged bytes are
//    buffered in a first-word-fall-through FIFO and presented on a
//    valid/ready stream.
//
// Ports
//    clk, reset_n     single clock; synchronous active-low reset
//    dout             serial data bit
//    valido_n         active-low: dout carries a valid bit this cycle
//    frameo_n         active-low frame; goes high on the final bit of a packet
//    m_data/m_last/m_err/m_valid/m_ready
//                     FIFO head stream; pop on m_valid && m_ready
//    fifo_level       current FIFO occupancy
//    frame_err        1-cycle pulse: malformed close or stray bit
//    ovf              1-cycle pulse: entry dropped because the FIFO was full
//    pkt_cnt          packets closed, including malformed ones (wraps)
//    drop_cnt         dropped entries (saturates)
module router_port_receiver #(
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        dout,
   input  logic                        valido_n,
   input  logic                        frameo_n,
   output logic [7:0]                  m_data,
   output logic                        m_last,
   output logic                        m_err,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        frame_err,
   output logic                        ovf,
   output logic [CNT_W-1:0]            pkt_cnt,
   output logic [CNT_W-1:0]            drop_cnt
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {S_SYNC, S_IDLE, S_RECV} state_t;

   state_t        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    byte_w;         // collected bits plus this cycle's bit, if any
   logic          push;
   logic [9:0]    push_entry;     // {err, last, data}
   logic          pkt_inc;
   logic          frame_err_d;

   // ---------------------------------------------------------------
   // Deserialiser FSM
   // ---------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      push        = 1'b0;
      push_entry  = '0;
      pkt_inc     = 1'b0;
      frame_err_d = 1'b0;
      byte_w      = shift_q;
      if (!valido_n)
         byte_w = shift_q | (8'(dout) << bit_cnt_q);

      case (state_q)
         // Whatever frame was in flight at reset is skipped entirely.
         S_SYNC: begin
            if (frameo_n)
               state_d = S_IDLE;
         end
         S_IDLE: begin
            if (!frameo_n) begin
               // The opening cycle may already carry bit 0.
               state_d   = S_RECV;
               shift_d   = {7'd0, !valido_n && dout};
               bit_cnt_d = valido_n ? 3'd0 : 3'd1;
            end else if (!valido_n) begin
               frame_err_d = 1'b1;
            end
         end
         S_RECV: begin
            if (frameo_n) begin
               state_d   = S_IDLE;
               pkt_inc   = 1'b1;
               push      = 1'b1;
               shift_d   = '0;
               bit_cnt_d = '0;
               // Only a close that lands exactly on the 8th bit is clean;
               // anything else flushes the partial byte flagged as an error.
               if (!valido_n && bit_cnt_q == 3'd7) begin
                  push_entry = {2'b01, byte_w};
               end else begin
                  push_entry  = {2'b11, byte_w};
                  frame_err_d = 1'b1;
               end
            end else if (!valido_n) begin
               if (bit_cnt_q == 3'd7) begin
                  push       = 1'b1;
                  push_entry = {2'b00, byte_w};
                  shift_d    = '0;
                  bit_cnt_d  = '0;
               end else begin
                  shift_d   = byte_w;
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         default: state_d = S_SYNC;
      endcase
   end

   // ---------------------------------------------------------------
   // FWFT FIFO
   // ---------------------------------------------------------------
   logic [9:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0] count_q;
   logic          full, pop, do_push, drop;
   logic [9:0]    head;

   assign m_valid = (count_q != '0);
   assign full    = (count_q == LW'(FIFO_DEPTH));
   assign pop     = m_valid && m_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push = push && (!full || pop);
   assign drop    = push && full && !pop;

   // The head slot is never written while occupied and not popped, so the
   // outputs stay stable under back-pressure. The RAM has no reset, hence
   // the gating on m_valid.
   assign head   = mem[rd_ptr_q];
   assign m_data = m_valid ? head[7:0] : 8'h00;
   assign m_last = m_valid && head[8];
   assign m_err  = m_valid && head[9];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr_q] <= push_entry;
   end

   logic             frame_err_q, ovf_q;
   logic [CNT_W-1:0] pkt_cnt_q, drop_cnt_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_SYNC;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         frame_err_q <= 1'b0;
         ovf_q       <= 1'b0;
         pkt_cnt_q   <= '0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         ovf_q       <= drop;
         if (do_push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + LW'(do_push) - LW'(pop);
         if (pkt_inc)
            pkt_cnt_q <= pkt_cnt_q + 1'b1;
         if (drop && drop_cnt_q != '1)
            drop_cnt_q <= drop_cnt_q + 1'b1;
      end
   end

   assign fifo_level = count_q;
   assign frame_err  = frame_err_q;
   assign ovf        = ovf_q;
   assign pkt_cnt    = pkt_cnt_q;
   assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_router_port_receiver.sv
// tb_router_port_receiver
//    Drives router_port_receiver (FIFO_DEPTH=4) with directed and random
//    serial traffic. A bit-queue / entry-queue reference model predicts the
//    FIFO contents, popped entries, pulse counts and counters.
module tb_router_port_receiver;
   localparam int DEPTH = 4;
   localparam int CNT_W = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset_n, dout, valido_n, frameo_n, m_ready;
   logic [7:0]       m_data;
   logic             m_last, m_err, m_valid, frame_err, ovf;
   logic [2:0]       fifo_level;
   logic [CNT_W-1:0] pkt_cnt, drop_cnt;

   router_port_receiver #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset_n(reset_n), .dout(dout), .valido_n(valido_n),
      .frameo_n(frameo_n), .m_data(m_data), .m_last(m_last), .m_err(m_err),
      .m_valid(m_valid), .m_ready(m_ready), .fifo_level(fifo_level),
      .frame_err(frame_err), .ovf(ovf), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
   );

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [9:0] mq[$];        // expected FIFO contents {err,last,data}
   logic [9:0] exp_pop[$];   // entries the model says are consumed
   logic [9:0] obs_pop[$];   // entries actually consumed from the DUT
   logic       bitq[$];      // bits of the byte being collected
   bit         m_synced, m_in_frame;
   int         exp_pkt, exp_drop, exp_ferr, exp_ovf, obs_ferr, obs_ovf;

   function automatic logic [7:0] bits_to_byte();
      logic [7:0] b = 8'h00;
      for (int i = 0; i < bitq.size(); i++) b[i] = bitq[i];
      return b;
   endfunction

   function automatic void model_reset();
      mq.delete(); exp_pop.delete(); obs_pop.delete(); bitq.delete();
      m_synced = 0; m_in_frame = 0;
      exp_pkt = 0; exp_drop = 0; exp_ferr = 0; exp_ovf = 0; obs_ferr = 0; obs_ovf = 0;
   endfunction

   // One sampled cycle, expressed in terms of packets and bytes.
   function automatic void model_cycle(input logic f, input logic v, input logic d, input logic r);
      bit gen = 0;
      logic [9:0] ent = '0;
      if (!m_synced) begin
         if (f) m_synced = 1;
      end else if (!m_in_frame) begin
         if (!f) begin
            m_in_frame = 1;
            bitq.delete();
            if (!v) bitq.push_back(d);
         end else if (!v) begin
            exp_ferr++;
         end
      end else begin
         if (!v) bitq.push_back(d);
         if (f) begin
            exp_pkt++;
            gen = 1;
            if (bitq.size() == 8) ent = {2'b01, bits_to_byte()};
            else begin
               ent = {2'b11, bits_to_byte()};
               exp_ferr++;
            end
            bitq.delete();
            m_in_frame = 0;
         end else if (bitq.size() == 8) begin
            gen = 1;
            ent = {2'b00, bits_to_byte()};
            bitq.delete();
         end
      end
      if (r && mq.size() > 0) exp_pop.push_back(mq.pop_front());
      if (gen) begin
         if (mq.size() < DEPTH) mq.push_back(ent);
         else begin
            exp_ovf++;
            if (exp_drop < (2**CNT_W) - 1) exp_drop++;
         end
      end
   endfunction

   // Drive one cycle, record any pop, advance the model, sample after the edge.
   task automatic step(input logic f, input logic v, input logic d, input logic r);
      frameo_n = f; valido_n = v; dout = d; m_ready = r;
      if (r && m_valid) obs_pop.push_back({m_err, m_last, m_data});
      model_cycle(f, v, d, r);
      @(posedge clk);
      #1;
      obs_ferr += int'(frame_err);
      obs_ovf  += int'(ovf);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic close, input logic r);
      for (int i = 0; i < 8; i++) step(close && i == 7, 1'b0, b[i], r);
   endtask

   task automatic pad(input int n, input logic f, input logic r);
      repeat (n) step(f, 1'b1, 1'b0, r);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) begin
         frameo_n = 1'($urandom); valido_n = 1'($urandom);
         dout = 1'($urandom); m_ready = 1'($urandom);
         @(posedge clk);
         #1;
      end
      model_reset();
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
      checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got=%h exp=00", m_data); end
      checks++; if ({m_last, m_err} !== 2'b00) begin errors++; $display("FAIL reset_last_err got=%b exp=00", {m_last, m_err}); end
      checks++; if ({frame_err, ovf} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b exp=00", {frame_err, ovf}); end
      checks++; if (pkt_cnt !== '0 || drop_cnt !== '0) begin errors++; $display("FAIL reset_counters got=%h/%h exp=0/0", pkt_cnt, drop_cnt); end
      checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
      // Release in the middle of a frame: all of it must be ignored.
      reset_n = 1'b1;
      repeat (12) step(1'b0, 1'($urandom), 1'($urandom), 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      pad(2, 1'b1, 1'b0);
      checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL sync_no_push level got=%0d exp=0", fifo_level); end
      checks++; if (pkt_cnt !== '0) begin errors++; $display("FAIL sync_pkt_cnt got=%0d exp=0", pkt_cnt); end
      checks++; if (obs_ferr !== 0) begin errors++; $display("FAIL sync_frame_err pulses got=%0d exp=0", obs_ferr); end
   endtask

   task automatic test_single_packet();
      send_byte(8'hA5, 1'b0, 1'b0);
      checks++; if ({m_valid, m_last, m_data} !== {1'b1, 1'b0, 8'hA5})
         begin errors++; $display("FAIL single_latency got v=%b l=%b d=%h exp v=1 l=0 d=a5", m_valid, m_last, m_data); end
      pad(5, 1'b0, 1'b0);
      send_byte(8'h3C, 1'b1, 1'b0);
      checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL single_level got=%0d exp=2", fifo_level); end
      checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL single_pkt_cnt got=%0d exp=1", pkt_cnt); end
      pad(3, 1'b1, 1'b1);
      checks++; if (obs_pop.size() !== 2) begin errors++; $display("FAIL single_pop_count got=%0d exp=2", obs_pop.size()); end
      else begin
         checks++; if (obs_pop[0] !== 10'h0A5) begin errors++; $display("FAIL single_entry0 got=%h exp=0a5", obs_pop[0]); end
         checks++; if (obs_pop[1] !== 10'h13C) begin errors++; $display("FAIL single_entry1 got=%h exp=13c", obs_pop[1]); end
      end
      obs_pop.delete(); exp_pop.delete();
   endtask

   task automatic test_misaligned();
      int pat [11];
      int ferr0;
      pat = '{1, 0, 1, 1, 0, 0, 0, 0, 1, 1, 1};
      ferr0 = obs_ferr;
      for (int i = 0; i < 11; i++) step(i == 10, 1'b0, 1'(pat[i]), 1'b0);
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL misalign_pulse got=%b exp=1", frame_err); end
      step(1'b1, 1'b1, 1'b0, 1'b0);
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL misalign_pulse_end got=%b exp=0", frame_err); end
      checks++; if (obs_ferr - ferr0 !== 1) begin errors++; $display("FAIL misalign_pulse_count got=%0d exp=1", obs_ferr - ferr0); end
      pad(3, 1'b1, 1'b1);
      checks++; if (obs_pop.size() !== 2) begin errors++; $display("FAIL misalign_pop_count got=%0d exp=2", obs_pop.size()); end
      else begin
         checks++; if (obs_pop[0] !== 10'h00D) begin errors++; $display("FAIL misalign_entry0 got=%h exp=00d", obs_pop[0]); end
         checks++; if (obs_pop[1] !== 10'h307) begin errors++; $display("FAIL misalign_entry1 got=%h exp=307", obs_pop[1]); end
      end
      obs_pop.delete(); exp_pop.delete();
   endtask

   task automatic test_overflow();
      logic [7:0] b [6];
      int ovf0, pkt0;
      ovf0 = obs_ovf; pkt0 = int'(pkt_cnt);
      foreach (b[i]) b[i] = 8'($urandom);
      for (int i = 0; i < 6; i++) send_byte(b[i], i == 5, 1'b0);
      checks++; if (obs_ovf - ovf0 !== 2) begin errors++; $display("FAIL ovf_pulses got=%0d exp=2", obs_ovf - ovf0); end
      checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_drop_cnt got=%0d exp=2", drop_cnt); end
      checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level got=%0d exp=4", fifo_level); end
      checks++; if (int'(pkt_cnt) - pkt0 !== 1) begin errors++; $display("FAIL ovf_pkt_cnt delta got=%0d exp=1", int'(pkt_cnt) - pkt0); end
      checks++; if (m_data !== b[0]) begin errors++; $display("FAIL ovf_head_hold got=%h exp=%h", m_data, b[0]); end
      pad(6, 1'b1, 1'b1);
      checks++; if (obs_pop.size() !== 4) begin errors++; $display("FAIL ovf_pop_count got=%0d exp=4", obs_pop.size()); end
      else for (int i = 0; i < 4; i++) begin
         checks++; if (obs_pop[i] !== {2'b00, b[i]}) begin errors++; $display("FAIL ovf_entry%0d got=%h exp=%h", i, obs_pop[i], {2'b00, b[i]}); end
      end
      obs_pop.delete(); exp_pop.delete();
   endtask

   task automatic test_full_pop();
      logic [7:0] b [5];
      int ovf0;
      foreach (b[i]) b[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) send_byte(b[i], 1'b0, 1'b0);
      checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL fullpop_fill got=%0d exp=4", fifo_level); end
      ovf0 = obs_ovf;
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, b[4][i], i == 7);
      checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL fullpop_level got=%0d exp=4", fifo_level); end
      checks++; if (drop_cnt !== 16'd2 || obs_ovf !== ovf0) begin errors++; $display("FAIL fullpop_no_drop got drop=%0d ovf=%0d exp drop=2 ovf=%0d", drop_cnt, obs_ovf, ovf0); end
      pad(6, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      pad(2, 1'b1, 1'b1);
      checks++; if (obs_pop.size() !== 6) begin errors++; $display("FAIL fullpop_pop_count got=%0d exp=6", obs_pop.size()); end
      else begin
         checks++; if (obs_pop[4] !== {2'b00, b[4]}) begin errors++; $display("FAIL fullpop_kept got=%h exp=%h", obs_pop[4], {2'b00, b[4]}); end
         checks++; if (obs_pop[5] !== 10'h300) begin errors++; $display("FAIL fullpop_err_close got=%h exp=300", obs_pop[5]); end
         foreach (exp_pop[i]) begin
            checks++; if (obs_pop[i] !== exp_pop[i]) begin errors++; $display("FAIL fullpop_model%0d got=%h exp=%h", i, obs_pop[i], exp_pop[i]); end
         end
      end
      obs_pop.delete(); exp_pop.delete();
   endtask

   task automatic test_back_to_back();
      logic [7:0] x, y;
      int pkt0;
      x = 8'($urandom); y = 8'($urandom);
      pkt0 = int'(pkt_cnt);
      send_byte(x, 1'b1, 1'b0);
      send_byte(y, 1'b1, 1'b0);
      checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL b2b_level got=%0d exp=2", fifo_level); end
      checks++; if (int'(pkt_cnt) - pkt0 !== 2) begin errors++; $display("FAIL b2b_pkt_cnt delta got=%0d exp=2", int'(pkt_cnt) - pkt0); end
      step(1'b1, 1'b0, 1'b1, 1'b0);
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL stray_pulse got=%b exp=1", frame_err); end
      checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL stray_no_push got=%0d exp=2", fifo_level); end
      pad(3, 1'b1, 1'b1);
      checks++; if (obs_pop.size() !== 2) begin errors++; $display("FAIL b2b_pop_count got=%0d exp=2", obs_pop.size()); end
      else begin
         checks++; if (obs_pop[0] !== {2'b01, x}) begin errors++; $display("FAIL b2b_entry0 got=%h exp=%h", obs_pop[0], {2'b01, x}); end
         checks++; if (obs_pop[1] !== {2'b01, y}) begin errors++; $display("FAIL b2b_entry1 got=%h exp=%h", obs_pop[1], {2'b01, y}); end
      end
      obs_pop.delete(); exp_pop.delete();
   endtask

   task automatic test_random();
      for (int fr = 0; fr < 40; fr++) begin
         int  gap, nbits;
         logic close_valid;
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++)
            step(1'b1, ($urandom_range(0, 5) != 0), 1'($urandom), 1'($urandom));
         nbits = int'($urandom_range(1, 20));
         close_valid = 1'($urandom);
         for (int i = 0; i < nbits; i++) begin
            if ($urandom_range(0, 3) == 0) step(1'b0, 1'b1, 1'($urandom), 1'($urandom));
            step(close_valid && i == nbits - 1, 1'b0, 1'($urandom), 1'($urandom));
         end
         if (!close_valid) step(1'b1, 1'b1, 1'b0, 1'($urandom));
      end
      pad(10, 1'b1, 1'b1);
      checks++; if (obs_pop.size() !== exp_pop.size()) begin errors++; $display("FAIL rand_pop_count got=%0d exp=%0d", obs_pop.size(), exp_pop.size()); end
      foreach (exp_pop[i]) if (i < obs_pop.size()) begin
         checks++; if (obs_pop[i] !== exp_pop[i]) begin errors++; $display("FAIL rand_entry%0d got=%h exp=%h", i, obs_pop[i], exp_pop[i]); end
      end
      checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rand_level got=%0d exp=0", fifo_level); end
      checks++; if (pkt_cnt !== CNT_W'(exp_pkt)) begin errors++; $display("FAIL rand_pkt_cnt got=%0d exp=%0d", pkt_cnt, exp_pkt); end
      checks++; if (drop_cnt !== CNT_W'(exp_drop)) begin errors++; $display("FAIL rand_drop_cnt got=%0d exp=%0d", drop_cnt, exp_drop); end
      checks++; if (obs_ferr !== exp_ferr) begin errors++; $display("FAIL rand_frame_err pulses got=%0d exp=%0d", obs_ferr, exp_ferr); end
      checks++; if (obs_ovf !== exp_ovf) begin errors++; $display("FAIL rand_ovf pulses got=%0d exp=%0d", obs_ovf, exp_ovf); end
      obs_pop.delete(); exp_pop.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; dout = 1'b0; valido_n = 1'b1; frameo_n = 1'b1; m_ready = 1'b0;
      model_reset();
      test_reset();
      $display("test_reset done: errors=%0d", errors);
      test_single_packet();
      $display("test_single_packet done: errors=%0d", errors);
      test_misaligned();
      $display("test_misaligned done: errors=%0d", errors);
      test_overflow();
      $display("test_overflow done: errors=%0d", errors);
      test_full_pop();
      $display("test_full_pop done: errors=%0d", errors);
      test_back_to_back();
      $display("test_back_to_back done: errors=%0d", errors);
      test_random();
      $display("test_random done: errors=%0d", errors);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
